// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path.
// Holds the parity mode constants, the receiver FSM state encoding and the layout
// of a FIFO entry ({break, parity_err, frame_err, data[7:0]}).
package uart_pkg;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_EVEN = 1;
    localparam int unsigned PAR_ODD  = 2;

    localparam int unsigned ENTRY_W = 11;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StBrkWait
    } rx_state_e;

    typedef struct packed {
        logic       brk;
        logic       parity_err;
        logic       frame_err;
        logic [7:0] data;
    } rx_entry_t;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Read-side bundle of the UART receiver.
//   master : receiver side, drives the head entry, valid, overrun and line_busy,
//            takes rx_ready.
//   slave  : consumer side, the mirror image.
interface uart_rx_fifo_if;

    logic [7:0] rx_byte;
    logic       rx_frame_err;
    logic       rx_parity_err;
    logic       rx_break;
    logic       rx_valid;
    logic       rx_ready;
    logic       overrun;
    logic       line_busy;

    modport master (
        output rx_byte,
        output rx_frame_err,
        output rx_parity_err,
        output rx_break,
        output rx_valid,
        input  rx_ready,
        output overrun,
        output line_busy
    );

    modport slave (
        input  rx_byte,
        input  rx_frame_err,
        input  rx_parity_err,
        input  rx_break,
        input  rx_valid,
        output rx_ready,
        input  overrun,
        input  line_busy
    );

endinterface

// File: rtl/uart_sync_fifo.sv
// Show-ahead synchronous FIFO with asynchronous active-high reset.
// Ports:
//   clk100, reset      : clock, async reset (empties the FIFO)
//   wr_en_i, wr_data_i : write request; accepted when not full or when a pop
//                        happens in the same cycle
//   full_o, empty_o    : occupancy flags
//   rd_en_i            : pop the head entry (ignored while empty)
//   rd_data_o          : head entry, reads 0 while empty
module uart_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk100,
    input  logic             reset,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    output logic             full_o,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PtrOne = {{AW{1'b0}}, 1'b1};

    // One extra pointer bit distinguishes full from empty when the indices match.
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_wr, do_rd;

    always_comb begin
        empty_o = (wr_ptr_q == rd_ptr_q);
        full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_rd   = rd_en_i && !empty_o;
        // A simultaneous pop frees the slot, so a write into a full FIFO still lands.
        do_wr   = wr_en_i && (!full_o || do_rd);

        wr_ptr_d = do_wr ? wr_ptr_q + PtrOne : wr_ptr_q;
        rd_ptr_d = do_rd ? rd_ptr_q + PtrOne : rd_ptr_q;

        mem_d = mem_q;
        if (do_wr) begin
            mem_d[wr_ptr_q[AW-1:0]] = wr_data_i;
        end

        rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge clk100 or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: it is only observed through a non-empty head.
    always_ff @(posedge clk100) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// Parametrised UART receiver with a buffered read side.
// Ports:
//   clk100 : system clock
//   reset  : asynchronous, active-high; abandons any frame and flushes the FIFO
//   rx     : asynchronous serial line, idle high
//   bus    : read side (head entry, valid/ready, overrun pulse, line_busy)
// Each bit is decided by a 3-sample majority vote around mid-bit; completed frames
// are pushed with framing/parity/break flags into a show-ahead FIFO.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 868,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic           clk100,
    input  logic           reset,
    input  logic           rx,
    uart_rx_fifo_if.master bus
);

    localparam int unsigned HALF     = CLK_DIV / 2;
    localparam logic [15:0] CntLast  = 16'(CLK_DIV - 1);
    localparam logic [15:0] CntS0    = 16'(HALF - 1);
    localparam logic [15:0] CntS1    = 16'(HALF);
    localparam logic [15:0] CntVote  = 16'(HALF + 1);
    localparam logic [2:0]  DataLast = 3'(DATA_BITS - 1);

    logic        sync1_q, sync1_d;
    logic        rxs_q, rxs_d;
    logic        rxs_prev_q, rxs_prev_d;
    rx_state_e   state_q, state_d;
    logic [15:0] bit_cnt_q, bit_cnt_d;
    logic        s0_q, s0_d;
    logic        s1_q, s1_d;
    logic [2:0]  data_idx_q, data_idx_d;
    logic        stop_idx_q, stop_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        par_bit_q, par_bit_d;
    logic        ferr_q, ferr_d;
    logic        push_q, push_d;
    rx_entry_t   entry_q, entry_d;

    logic        fall, vote_tick, voted, par_exp, par_err, is_break;
    logic        fifo_full, fifo_empty, pop;
    rx_entry_t   head;

    always_comb begin
        sync1_d    = rx;
        rxs_d      = sync1_q;
        rxs_prev_d = rxs_q;

        fall      = rxs_prev_q && !rxs_q;
        vote_tick = (bit_cnt_q == CntVote);
        voted     = (s0_q & s1_q) | (s0_q & rxs_q) | (s1_q & rxs_q);

        par_exp  = (^shift_q) ^ (PARITY == PAR_ODD);
        par_err  = (PARITY != PAR_NONE) && (par_bit_q != par_exp);
        is_break = (shift_q == 8'h00) && ((PARITY == PAR_NONE) || !par_bit_q) && !voted;

        state_d    = state_q;
        bit_cnt_d  = (bit_cnt_q == CntLast) ? 16'd0 : bit_cnt_q + 16'd1;
        s0_d       = (bit_cnt_q == CntS0) ? rxs_q : s0_q;
        s1_d       = (bit_cnt_q == CntS1) ? rxs_q : s1_q;
        data_idx_d = data_idx_q;
        stop_idx_d = stop_idx_q;
        shift_d    = shift_q;
        par_bit_d  = par_bit_q;
        ferr_d     = ferr_q;
        push_d     = 1'b0;
        entry_d    = entry_q;

        unique case (state_q)
            StIdle: begin
                if (fall) begin
                    state_d   = StStart;
                    bit_cnt_d = 16'd0;
                end
            end
            StStart: begin
                if (vote_tick) begin
                    if (voted) begin
                        state_d = StIdle;
                    end else begin
                        state_d    = StData;
                        data_idx_d = 3'd0;
                        stop_idx_d = 1'b0;
                        shift_d    = 8'h00;
                        par_bit_d  = 1'b0;
                        ferr_d     = 1'b0;
                    end
                end
            end
            StData: begin
                if (vote_tick) begin
                    // Bits above DATA_BITS stay 0 because the register is cleared on start.
                    shift_d              = shift_q >> 1;
                    shift_d[DATA_BITS-1] = voted;
                    if (data_idx_q == DataLast) begin
                        state_d = (PARITY != PAR_NONE) ? StParity : StStop;
                    end else begin
                        data_idx_d = data_idx_q + 3'd1;
                    end
                end
            end
            StParity: begin
                if (vote_tick) begin
                    par_bit_d = voted;
                    state_d   = StStop;
                end
            end
            StStop: begin
                if (vote_tick) begin
                    ferr_d = ferr_q | !voted;
                    if (!stop_idx_q && is_break) begin
                        // Parity is meaningless on a break, so it is not flagged.
                        push_d             = 1'b1;
                        entry_d.brk        = 1'b1;
                        entry_d.parity_err = 1'b0;
                        entry_d.frame_err  = 1'b1;
                        entry_d.data       = shift_q;
                        state_d            = StBrkWait;
                    end else if (!stop_idx_q && (STOP_BITS == 2)) begin
                        stop_idx_d = 1'b1;
                    end else begin
                        // Back to idle mid stop bit so a following start edge is caught.
                        push_d             = 1'b1;
                        entry_d.brk        = 1'b0;
                        entry_d.parity_err = par_err;
                        entry_d.frame_err  = ferr_q | !voted;
                        entry_d.data       = shift_q;
                        state_d            = StIdle;
                    end
                end
            end
            StBrkWait: begin
                if (rxs_q) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk100 or posedge reset) begin
        if (reset) begin
            sync1_q    <= 1'b1;
            rxs_q      <= 1'b1;
            rxs_prev_q <= 1'b1;
            state_q    <= StIdle;
            bit_cnt_q  <= 16'd0;
            s0_q       <= 1'b1;
            s1_q       <= 1'b1;
            data_idx_q <= 3'd0;
            stop_idx_q <= 1'b0;
            shift_q    <= 8'h00;
            par_bit_q  <= 1'b0;
            ferr_q     <= 1'b0;
            push_q     <= 1'b0;
            entry_q    <= '0;
        end else begin
            sync1_q    <= sync1_d;
            rxs_q      <= rxs_d;
            rxs_prev_q <= rxs_prev_d;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            s0_q       <= s0_d;
            s1_q       <= s1_d;
            data_idx_q <= data_idx_d;
            stop_idx_q <= stop_idx_d;
            shift_q    <= shift_d;
            par_bit_q  <= par_bit_d;
            ferr_q     <= ferr_d;
            push_q     <= push_d;
            entry_q    <= entry_d;
        end
    end

    uart_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk100    (clk100),
        .reset     (reset),
        .wr_en_i   (push_q),
        .wr_data_i (entry_q),
        .full_o    (fifo_full),
        .rd_en_i   (pop),
        .rd_data_o (head),
        .empty_o   (fifo_empty)
    );

    assign pop               = !fifo_empty && bus.rx_ready;
    assign bus.rx_valid      = !fifo_empty;
    assign bus.rx_byte       = head.data;
    assign bus.rx_frame_err  = head.frame_err;
    assign bus.rx_parity_err = head.parity_err;
    assign bus.rx_break      = head.brk;
    assign bus.overrun       = push_q && fifo_full && !pop;
    assign bus.line_busy     = (state_q != StIdle);

endmodule
